tile_flatten_loader: RTL and testbench

Sequencing controller that fills a ROWS×COLS tile of BIT_WIDTH elements from a serial valid/ready element stream. It presents the completed tile as one flattened bus over a valid/ready handshake. It sits between an element producer, such as a memory reader or a systolic array output drain, and consumers that take a packed column-major tile vector.

---
 rtl/tile_pkg.sv | 19 +
 rtl/tile_flatten_loader_if.sv | 28 ++
 rtl/tile_bank.sv | 48 ++++
 rtl/tile_flatten_loader.sv | 148 ++++++++++++++
 tb/tb_tile_flatten_loader.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tile_pkg.sv
// Shared types and index helpers for the tile flatten loader.
package tile_pkg;

   typedef enum logic {
      LOAD,
      FULL
   } tile_state_t;

   // Column-major slot of element (r,c) in the flattened tile vector.
   function automatic int unsigned slot(input int unsigned r, input int unsigned c,
                                        input int unsigned rows);
      return c * rows + r;
   endfunction

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tile_flatten_loader_if.sv
// Element-stream and tile-stream handshake bundle for tile_flatten_loader.
interface tile_flatten_loader_if #(
   parameter int unsigned BIT_WIDTH = 4,
   parameter int unsigned ROWS      = 8,
   parameter int unsigned COLS      = 8
);
   localparam int unsigned N  = ROWS * COLS;
   localparam int unsigned CW = $clog2(N + 1);

   logic                   in_valid;
   logic                   in_ready;
   logic [BIT_WIDTH-1:0]   in_data;
   logic                   tile_valid;
   logic                   tile_ready;
   logic [N*BIT_WIDTH-1:0] tile_data;
   logic [CW-1:0]          fill_count;

   modport master (
      output in_valid, in_data, tile_ready,
      input  in_ready, tile_valid, tile_data, fill_count
   );

   modport slave (
      input  in_valid, in_data, tile_ready,
      output in_ready, tile_valid, tile_data, fill_count
   );

endinterface

// File: rtl/tile_bank.sv
// One ROWS x COLS element register array, written by (row,col) and read as a
// column-major flattened vector.
module tile_bank
   import tile_pkg::*;
#(
   parameter int unsigned BIT_WIDTH = 4,
   parameter int unsigned ROWS      = 8,
   parameter int unsigned COLS      = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          we,
   input  logic [idx_width(ROWS)-1:0]    row,
   input  logic [idx_width(COLS)-1:0]    col,
   input  logic [BIT_WIDTH-1:0]          wdata,
   output logic [ROWS*COLS*BIT_WIDTH-1:0] flat
);
   localparam int unsigned RW  = idx_width(ROWS);
   localparam int unsigned CLW = idx_width(COLS);

   logic [BIT_WIDTH-1:0] mem_q [ROWS][COLS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
               mem_q[r][c] <= '0;
            end
         end
      end else begin
         for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
               if (we && row == RW'(r) && col == CLW'(c)) begin
                  mem_q[r][c] <= wdata;
               end
            end
         end
      end
   end

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      for (genvar c = 0; c < COLS; c++) begin : g_col
         localparam int unsigned K = slot(r, c, ROWS);
         assign flat[K*BIT_WIDTH +: BIT_WIDTH] = mem_q[r][c];
      end
   end

endmodule

// File: rtl/tile_flatten_loader.sv
// Loads a ROWS x COLS tile from a row-major element stream and presents it as a
// column-major flat bus. Define TILE_FLATTEN_LOADER_PINGPONG_EN for two banks.
module tile_flatten_loader
   import tile_pkg::*;
#(
   parameter int unsigned BIT_WIDTH = 4,
   parameter int unsigned ROWS      = 8,
   parameter int unsigned COLS      = 8
) (
   input logic                  clk,
   input logic                  rst_n,
   input logic                  flush,
   tile_flatten_loader_if.slave bus
);
   localparam int unsigned N   = ROWS * COLS;
   localparam int unsigned CW  = $clog2(N + 1);
   localparam int unsigned RW  = idx_width(ROWS);
   localparam int unsigned CLW = idx_width(COLS);

   logic [RW-1:0]  row_q;
   logic [CLW-1:0] col_q;
   logic [CW-1:0]  fill_q;
   logic           store_en;
   logic           last_col;
   logic           last_row;
   logic           complete;
   logic           handshake;

   // A flush that coincides with an accepted element drops that element.
   assign store_en  = bus.in_valid && bus.in_ready && !flush;
   assign last_col  = (col_q == CLW'(COLS - 1));
   assign last_row  = (row_q == RW'(ROWS - 1));
   assign complete  = store_en && last_col && last_row;
   assign handshake = bus.tile_valid && bus.tile_ready;

   assign bus.fill_count = fill_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_q  <= '0;
         col_q  <= '0;
         fill_q <= '0;
      end else if (flush) begin
         row_q  <= '0;
         col_q  <= '0;
         fill_q <= '0;
      end else if (store_en) begin
         if (last_col) begin
            col_q <= '0;
            row_q <= last_row ? '0 : row_q + RW'(1);
         end else begin
            col_q <= col_q + CLW'(1);
         end
         fill_q <= complete ? '0 : fill_q + CW'(1);
      end
   end

`ifdef TILE_FLATTEN_LOADER_PINGPONG_EN
   tile_state_t            state_q [2];
   logic                   wr_q;
   logic                   rd_q;
   logic [N*BIT_WIDTH-1:0] flat0;
   logic [N*BIT_WIDTH-1:0] flat1;

   // Completion and handshake always target different banks, so both may fire.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q[0] <= LOAD;
         state_q[1] <= LOAD;
         wr_q       <= 1'b0;
         rd_q       <= 1'b0;
      end else begin
         if (complete) begin
            state_q[wr_q] <= FULL;
            wr_q          <= ~wr_q;
         end
         if (handshake) begin
            state_q[rd_q] <= LOAD;
            rd_q          <= ~rd_q;
         end
      end
   end

   assign bus.in_ready   = (state_q[wr_q] == LOAD);
   assign bus.tile_valid = (state_q[rd_q] == FULL);
   assign bus.tile_data  = rd_q ? flat1 : flat0;

   tile_bank #(
      .BIT_WIDTH (BIT_WIDTH),
      .ROWS      (ROWS),
      .COLS      (COLS)
   ) u_bank0 (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (store_en && !wr_q),
      .row   (row_q),
      .col   (col_q),
      .wdata (bus.in_data),
      .flat  (flat0)
   );

   tile_bank #(
      .BIT_WIDTH (BIT_WIDTH),
      .ROWS      (ROWS),
      .COLS      (COLS)
   ) u_bank1 (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (store_en && wr_q),
      .row   (row_q),
      .col   (col_q),
      .wdata (bus.in_data),
      .flat  (flat1)
   );
`else
   tile_state_t state_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= LOAD;
      end else begin
         case (state_q)
            LOAD:    if (complete)  state_q <= FULL;
            FULL:    if (handshake) state_q <= LOAD;
            default: state_q <= LOAD;
         endcase
      end
   end

   assign bus.in_ready   = (state_q == LOAD);
   assign bus.tile_valid = (state_q == FULL);

   tile_bank #(
      .BIT_WIDTH (BIT_WIDTH),
      .ROWS      (ROWS),
      .COLS      (COLS)
   ) u_bank0 (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (store_en),
      .row   (row_q),
      .col   (col_q),
      .wdata (bus.in_data),
      .flat  (bus.tile_data)
   );
`endif

endmodule

// File: tb/tb_tile_flatten_loader.sv
// Self-checking bench for tile_flatten_loader with a 2x3 tile of 4-bit elements.
module tb_tile_flatten_loader;
   localparam int unsigned BW   = 4;
   localparam int unsigned ROWS = 2;
   localparam int unsigned COLS = 3;
   localparam int unsigned N    = ROWS * COLS;
   localparam int unsigned CW   = $clog2(N + 1);

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   tile_flatten_loader_if #(.BIT_WIDTH(BW), .ROWS(ROWS), .COLS(COLS)) bus ();

   tile_flatten_loader #(
      .BIT_WIDTH (BW),
      .ROWS      (ROWS),
      .COLS      (COLS)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Element i of the row-major stream sits at row i/COLS, column i%COLS.
   function automatic logic [N*BW-1:0] pack_tile(input logic [BW-1:0] e [N]);
      logic [N*BW-1:0] t;
      t = '0;
      for (int i = 0; i < N; i++) begin
         t[((i % COLS) * ROWS + (i / COLS)) * BW +: BW] = e[i];
      end
      return t;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      bus.tile_ready = 1'b0;
      repeat (3) tick();
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
      end
      n_checks++;
      if (bus.tile_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_tile_valid got=%b exp=0", bus.tile_valid);
      end
      n_checks++;
      if (bus.fill_count !== CW'(0)) begin
         n_fail++; $display("FAIL reset_fill_count got=%0d exp=0", bus.fill_count);
      end
      n_checks++;
      if (bus.tile_data !== 24'h0) begin
         n_fail++; $display("FAIL reset_tile_data got=%h exp=000000", bus.tile_data);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_fill_stall();
      logic [N*BW-1:0] held;
      logic            exp_rdy;
      bus.tile_ready = 1'b0;
      for (int i = 1; i <= N; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = BW'(i);
         n_checks++;
         if (bus.in_ready !== 1'b1 || bus.tile_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_ready_elem%0d in_ready=%b tile_valid=%b exp 1/0",
                     i, bus.in_ready, bus.tile_valid);
         end
         tick();
      end
      n_checks++;
      if (bus.tile_valid !== 1'b1) begin
         n_fail++; $display("FAIL fill_tile_valid got=%b exp=1", bus.tile_valid);
      end
      n_checks++;
      if (bus.tile_data !== 24'h635241) begin
         n_fail++; $display("FAIL fill_tile_data got=%h exp=635241", bus.tile_data);
      end
      held = bus.tile_data;
`ifdef TILE_FLATTEN_LOADER_PINGPONG_EN
      bus.in_valid = 1'b0;
      exp_rdy = 1'b1;
`else
      // Offered elements must be refused while the only bank is full.
      bus.in_valid = 1'b1;
      bus.in_data  = 4'hF;
      exp_rdy = 1'b0;
`endif
      for (int k = 0; k < 10; k++) begin
         n_checks++;
         if (bus.in_ready !== exp_rdy || bus.tile_valid !== 1'b1 || bus.tile_data !== held ||
             bus.fill_count !== CW'(0)) begin
            n_fail++;
            $display("FAIL stall_hold cyc%0d in_ready=%b exp=%b valid=%b data=%h exp=%h fill=%0d",
                     k, bus.in_ready, exp_rdy, bus.tile_valid, bus.tile_data, held,
                     bus.fill_count);
         end
         tick();
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic test_handshake();
      bus.tile_ready = 1'b1;
      tick();
      bus.tile_ready = 1'b0;
      n_checks++;
      if (bus.tile_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL handshake_release tile_valid=%b exp=0 in_ready=%b exp=1",
                  bus.tile_valid, bus.in_ready);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      logic [BW-1:0] e [N];
      for (int i = 0; i < 2; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = BW'(i + 9);
         tick();
      end
      bus.in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #3 rst_n = 1'b1;
      tick();
      n_checks++;
      if (bus.fill_count !== CW'(0) || bus.tile_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid fill=%0d exp=0 tile_valid=%b exp=0",
                  bus.fill_count, bus.tile_valid);
      end
      for (int i = 0; i < N; i++) begin
         e[i] = BW'($urandom);
         bus.in_valid = 1'b1;
         bus.in_data  = e[i];
         tick();
      end
      bus.in_valid = 1'b0;
      n_checks++;
      if (bus.tile_valid !== 1'b1 || bus.tile_data !== pack_tile(e)) begin
         n_fail++;
         $display("FAIL reset_mid_tile valid=%b data=%h exp=%h",
                  bus.tile_valid, bus.tile_data, pack_tile(e));
      end
      test_handshake();
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = BW'(i + 1);
         tick();
      end
      n_checks++;
      if (bus.fill_count !== CW'(3)) begin
         n_fail++; $display("FAIL flush_pre_fill got=%0d exp=3", bus.fill_count);
      end
      flush = 1'b1;
      bus.in_data = 4'h7;
      tick();
      flush = 1'b0;
      bus.in_valid = 1'b0;
      n_checks++;
      if (bus.fill_count !== CW'(0)) begin
         n_fail++; $display("FAIL flush_fill got=%0d exp=0", bus.fill_count);
      end
      for (int i = 0; i < N; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = BW'(10 + i);
         tick();
         if (i == 4) begin
            n_checks++;
            if (bus.fill_count !== CW'(5)) begin
               n_fail++; $display("FAIL flush_refill got=%0d exp=5", bus.fill_count);
            end
         end
      end
      bus.in_valid = 1'b0;
      n_checks++;
      if (bus.tile_valid !== 1'b1 || bus.tile_data !== 24'hFCEBDA || bus.fill_count !== CW'(0)) begin
         n_fail++;
         $display("FAIL flush_tile valid=%b data=%h exp=fcebda fill=%0d exp=0",
                  bus.tile_valid, bus.tile_data, bus.fill_count);
      end
      test_handshake();
   endtask

`ifdef TILE_FLATTEN_LOADER_PINGPONG_EN
   task automatic test_pingpong();
      bus.tile_ready = 1'b0;
      for (int i = 1; i <= 2 * N; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = BW'(i);
         n_checks++;
         if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL pp_ready_elem%0d got=%b exp=1", i, bus.in_ready);
         end
         tick();
      end
      bus.in_valid = 1'b0;
      n_checks++;
      if (bus.in_ready !== 1'b0 || bus.tile_valid !== 1'b1 || bus.tile_data !== 24'h635241) begin
         n_fail++;
         $display("FAIL pp_first in_ready=%b exp=0 valid=%b data=%h exp=635241",
                  bus.in_ready, bus.tile_valid, bus.tile_data);
      end
      bus.tile_ready = 1'b1;
      tick();
      bus.tile_ready = 1'b0;
      n_checks++;
      if (bus.in_ready !== 1'b1 || bus.tile_valid !== 1'b1 || bus.tile_data !== 24'hC9B8A7) begin
         n_fail++;
         $display("FAIL pp_second in_ready=%b exp=1 valid=%b data=%h exp=c9b8a7",
                  bus.in_ready, bus.tile_valid, bus.tile_data);
      end
      test_handshake();
   endtask
`endif

   task automatic test_random();
      logic [BW-1:0]   cur [N];
      logic [N*BW-1:0] exp_q [$];
      logic [N*BW-1:0] prev_data;
      logic [N*BW-1:0] exp_t;
      logic            prev_pending;
      int              cnt;
      int              sent;
      int              rx;
      int              cycles;
      cnt = 0; sent = 0; rx = 0; cycles = 0;
      prev_pending = 1'b0;
      prev_data = '0;
      while (rx < 50 && cycles < 6000) begin
         if (prev_pending) begin
            n_checks++;
            if (bus.tile_valid !== 1'b1 || bus.tile_data !== prev_data) begin
               n_fail++;
               $display("FAIL rand_hold cyc%0d valid=%b data=%h exp=%h",
                        cycles, bus.tile_valid, bus.tile_data, prev_data);
            end
         end
         n_checks++;
         if (bus.fill_count !== CW'(cnt)) begin
            n_fail++;
            $display("FAIL rand_fill cyc%0d got=%0d exp=%0d", cycles, bus.fill_count, cnt);
         end
         bus.in_valid   = (sent < 50 * N) && ($urandom_range(0, 3) != 0);
         bus.in_data    = BW'($urandom);
         bus.tile_ready = ($urandom_range(0, 2) != 0);
         if (bus.in_valid && bus.in_ready) begin
            cur[cnt] = bus.in_data;
            cnt++;
            sent++;
            if (cnt == N) begin
               exp_q.push_back(pack_tile(cur));
               cnt = 0;
            end
         end
         if (bus.tile_valid && bus.tile_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL rand_extra_tile got=%h exp=none", bus.tile_data);
            end else begin
               exp_t = exp_q.pop_front();
               if (bus.tile_data !== exp_t) begin
                  n_fail++;
                  $display("FAIL rand_tile%0d got=%h exp=%h", rx, bus.tile_data, exp_t);
               end
            end
            rx++;
         end
         prev_pending = bus.tile_valid && !bus.tile_ready;
         prev_data    = bus.tile_data;
         tick();
         cycles++;
      end
      bus.in_valid = 1'b0;
      bus.tile_ready = 1'b0;
      n_checks++;
      if (rx != 50 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL rand_count got=%0d tiles pending=%0d exp=50 tiles pending=0",
                  rx, exp_q.size());
      end
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      bus.tile_ready = 1'b0;
      test_reset();
      test_fill_stall();
      test_handshake();
      test_reset_mid();
      test_flush();
`ifdef TILE_FLATTEN_LOADER_PINGPONG_EN
      test_pingpong();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
